// File: rtl/kmeans_k3n2_centroid_update_pkg.sv
// Shared constants, state encoding and width helpers for the k-means centroid update stage.
package kmeans_k3n2_centroid_update_pkg;

    // Centroid indices as carried on in_sel; K_DROP marks a sample to discard.
    localparam logic [1:0] K0     = 2'd0;
    localparam logic [1:0] K1     = 2'd1;
    localparam logic [1:0] K2     = 2'd2;
    localparam logic [1:0] K_DROP = 2'd3;

    // Six coordinates in division order: k0d0, k0d1, k1d0, k1d1, k2d0, k2d1.
    localparam int N_COORD    = 6;
    localparam int LAST_COORD = N_COORD - 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACC       = 3'd1,
        S_DIV_LOAD  = 3'd2,
        S_DIV_RUN   = 3'd3,
        S_DIV_WRITE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Sum of up to 2**qb samples of dw-bit coordinates.
    function automatic int sum_width(input int dw, input int qb);
        return dw + qb;
    endfunction

    // Count must reach 2**qb itself, hence one extra bit.
    function automatic int cnt_width(input int qb);
        return qb + 1;
    endfunction

endpackage

// File: rtl/kmeans_k3n2_centroid_update_if.sv
// Classified-sample stream from the distance pipeline into the centroid update stage.
interface kmeans_k3n2_centroid_update_if #(
    parameter int DW = 8
) ();
    logic          in_valid;
    logic          in_last;
    logic [DW-1:0] in_d0;
    logic [DW-1:0] in_d1;
    logic [1:0]    in_sel;

    modport master (output in_valid, output in_last, output in_d0, output in_d1, output in_sel);
    modport slave  (input  in_valid, input  in_last, input  in_d0, input  in_d1, input  in_sel);
endinterface

// File: rtl/kmeans_k3n2_centroid_update_divider.sv
// Restoring sequential divider: one quotient bit per cycle, SW cycles after load.
// A zero divisor produces an all-ones quotient; the caller discards it.
module kmeans_seq_divider #(
    parameter int SW = 16,
    parameter int QW = SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [SW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic          ready
);
    localparam int STPW = $clog2(SW + 1);

    logic [SW-1:0]   rem_q, rem_d;
    logic [SW-1:0]   quo_q, quo_d;
    logic [SW-1:0]   dvs_q, dvs_d;
    logic [STPW-1:0] step_q, step_d;
    logic [SW:0]     rem_shift;
    logic [SW:0]     trial;

    // Divider registers; iteration counter runs down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            step_q <= step_d;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        step_d    = step_q;
        rem_shift = {rem_q, quo_q[SW-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        if (load) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            step_d = STPW'(SW);
        end else if (step_q != '0) begin
            step_d = step_q - STPW'(1);
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = trial[SW-1:0];
                quo_d = {quo_q[SW-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[SW-1:0];
                quo_d = {quo_q[SW-2:0], 1'b0};
            end
        end
    end

    assign quotient = quo_q[QW-1:0];
    assign ready    = (step_q == '0);

endmodule

// File: rtl/kmeans_k3n2_centroid_update.sv
// Accumulates per-centroid sums/counts over one pass, then divides them
// one coordinate at a time through a shared divider to form new centroids.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start; results and converged held
// S_ACC       | accepting classified samples until in_valid && in_last
// S_DIV_LOAD  | load sum[j] / cnt[j/2] into the divider
// S_DIV_RUN   | divider iterating, SW cycles
// S_DIV_WRITE | store mean (or old value if count is 0), fold into converged
// S_DONE      | one-cycle done pulse
module kmeans_k3n2_centroid_update
    import kmeans_k3n2_centroid_update_pkg::*;
#(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    kmeans_k3n2_centroid_update_if.slave  smp,
    input  logic [input_data_width-1:0]   old_k0d0,
    input  logic [input_data_width-1:0]   old_k0d1,
    input  logic [input_data_width-1:0]   old_k1d0,
    input  logic [input_data_width-1:0]   old_k1d1,
    input  logic [input_data_width-1:0]   old_k2d0,
    input  logic [input_data_width-1:0]   old_k2d1,
    output logic [input_data_width-1:0]   new_k0d0,
    output logic [input_data_width-1:0]   new_k0d1,
    output logic [input_data_width-1:0]   new_k1d0,
    output logic [input_data_width-1:0]   new_k1d1,
    output logic [input_data_width-1:0]   new_k2d0,
    output logic [input_data_width-1:0]   new_k2d1,
    output logic                          busy,
    output logic                          done,
    output logic                          converged
);
    localparam int DW   = input_data_width;
    localparam int SW   = sum_width(input_data_width, input_data_qty_bit_width);
    localparam int CW   = cnt_width(input_data_qty_bit_width);
    localparam int RUNW = $clog2(SW);

    localparam logic [RUNW-1:0] RUN_LAST = RUNW'(SW - 1);
    localparam logic [2:0]      J_LAST   = 3'(LAST_COORD);

    state_t                   state_q, state_d;
    logic [5:0][SW-1:0]       sum_q, sum_d;
    logic [2:0][CW-1:0]       cnt_q, cnt_d;
    logic [2:0]               j_q, j_d;
    logic [RUNW-1:0]          run_q, run_d;
    logic [5:0][DW-1:0]       new_q, new_d;
    logic                     conv_acc_q, conv_acc_d;
    logic                     converged_q, converged_d;

    logic [5:0][DW-1:0]       old_v;
    logic [CW-1:0]            cur_cnt;
    logic [DW-1:0]            wr_val;
    logic                     div_load;
    logic                     div_ready;
    logic [DW-1:0]            div_quot;
    logic                     accept_last;
    logic [2:0]               idx_d0;
    logic [2:0]               idx_d1;

    assign old_v       = {old_k2d1, old_k2d0, old_k1d1, old_k1d0, old_k0d1, old_k0d0};
    assign cur_cnt     = cnt_q[j_q[2:1]];
    assign accept_last = smp.in_valid && smp.in_last;
    assign idx_d0      = {smp.in_sel, 1'b0};
    assign idx_d1      = {smp.in_sel, 1'b1};

    kmeans_seq_divider #(
        .SW (SW),
        .QW (DW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst),
        .load     (div_load),
        .dividend (sum_q[j_q]),
        .divisor  (SW'(cur_cnt)),
        .quotient (div_quot),
        .ready    (div_ready)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_ACC;
            S_ACC:       if (accept_last) state_d = S_DIV_LOAD;
            S_DIV_LOAD:  state_d = S_DIV_RUN;
            S_DIV_RUN:   if (run_q == '0) state_d = S_DIV_WRITE;
            S_DIV_WRITE: if (div_ready) state_d = (j_q == J_LAST) ? S_DONE : S_DIV_LOAD;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath registers: sums, counts, coordinate index, run timer, results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q       <= '0;
            cnt_q       <= '0;
            j_q         <= '0;
            run_q       <= '0;
            new_q       <= '0;
            conv_acc_q  <= 1'b0;
            converged_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            run_q       <= run_d;
            new_q       <= new_d;
            conv_acc_q  <= conv_acc_d;
            converged_q <= converged_d;
        end
    end

    // Datapath next values per state.
    always_comb begin
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        j_d         = j_q;
        run_d       = run_q;
        new_d       = new_q;
        conv_acc_d  = conv_acc_q;
        converged_d = converged_q;
        div_load    = 1'b0;
        wr_val      = (cur_cnt == '0) ? old_v[j_q] : div_quot;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d      = '0;
                    cnt_d      = '0;
                    j_d        = '0;
                    conv_acc_d = 1'b1;
                end
            end
            S_ACC: begin
                if (smp.in_valid && smp.in_sel != K_DROP) begin
                    sum_d[idx_d0]     = sum_q[idx_d0] + SW'(smp.in_d0);
                    sum_d[idx_d1]     = sum_q[idx_d1] + SW'(smp.in_d1);
                    cnt_d[smp.in_sel] = cnt_q[smp.in_sel] + CW'(1);
                end
                if (accept_last) j_d = '0;
            end
            S_DIV_LOAD: begin
                div_load = 1'b1;
                run_d    = RUN_LAST;
            end
            S_DIV_RUN: begin
                if (run_q != '0) run_d = run_q - RUNW'(1);
            end
            S_DIV_WRITE: begin
                if (div_ready) begin
                    new_d[j_q] = wr_val;
                    conv_acc_d = conv_acc_q && (wr_val == old_v[j_q]);
                    if (j_q == J_LAST) converged_d = conv_acc_q && (wr_val == old_v[j_q]);
                    else               j_d = j_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign new_k0d0  = new_q[0];
    assign new_k0d1  = new_q[1];
    assign new_k1d0  = new_q[2];
    assign new_k1d1  = new_q[3];
    assign new_k2d0  = new_q[4];
    assign new_k2d1  = new_q[5];
    assign converged = converged_q;

endmodule

// File: tb/tb_kmeans_k3n2_centroid_update.sv
// Bench for the centroid update stage: directed and random passes against a mean model.
module tb_kmeans_k3n2_centroid_update;
    localparam int DW      = 8;
    localparam int QB      = 8;
    localparam int LATENCY = 6 * (DW + QB + 2);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [DW-1:0] old_v [6];
    logic [DW-1:0] new_v [6];
    logic busy, done, converged;

    always #5 clk = ~clk;

    kmeans_k3n2_centroid_update_if #(.DW(DW)) smp ();

    kmeans_k3n2_centroid_update #(
        .input_data_width         (DW),
        .input_data_qty_bit_width (QB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .smp       (smp),
        .old_k0d0  (old_v[0]),
        .old_k0d1  (old_v[1]),
        .old_k1d0  (old_v[2]),
        .old_k1d1  (old_v[3]),
        .old_k2d0  (old_v[4]),
        .old_k2d1  (old_v[5]),
        .new_k0d0  (new_v[0]),
        .new_k0d1  (new_v[1]),
        .new_k1d0  (new_v[2]),
        .new_k1d1  (new_v[3]),
        .new_k2d0  (new_v[4]),
        .new_k2d1  (new_v[5]),
        .busy      (busy),
        .done      (done),
        .converged (converged)
    );

    typedef struct {
        bit       v;
        bit       l;
        bit [7:0] d0;
        bit [7:0] d1;
        bit [1:0] sel;
    } smp_t;

    smp_t stim [$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_new [6];
    bit   exp_conv;

    // Reference: mean of every accepted sample per centroid; empty centroid keeps old value.
    task automatic model();
        int s [6];
        int c [3];
        for (int i = 0; i < 6; i++) s[i] = 0;
        for (int i = 0; i < 3; i++) c[i] = 0;
        foreach (stim[i]) begin
            if (stim[i].v && stim[i].sel != 2'd3) begin
                s[2*stim[i].sel]     += stim[i].d0;
                s[2*stim[i].sel + 1] += stim[i].d1;
                c[stim[i].sel]       += 1;
            end
        end
        exp_conv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_new[i] = (c[i/2] != 0) ? s[i] / c[i/2] : int'(old_v[i]);
            if (exp_new[i] != int'(old_v[i])) exp_conv = 1'b0;
        end
    endtask

    task automatic idle_bus();
        smp.in_valid = 1'b0;
        smp.in_last  = 1'b0;
        smp.in_d0    = '0;
        smp.in_d1    = '0;
        smp.in_sel   = '0;
    endtask

    task automatic push(input bit v, input bit l, input int d0, input int d1, input int sel);
        smp_t e;
        e.v = v; e.l = l; e.d0 = 8'(d0); e.d1 = 8'(d1); e.sel = 2'(sel);
        stim.push_back(e);
    endtask

    task automatic random_old();
        for (int i = 0; i < 6; i++) old_v[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic gen_random(input int n);
        stim.delete();
        for (int i = 0; i < n - 1; i++) begin
            smp_t e;
            e.v   = ($urandom_range(0, 3) != 0);
            e.l   = !e.v && ($urandom_range(0, 1) == 1);
            e.d0  = 8'($urandom_range(0, 255));
            e.d1  = 8'($urandom_range(0, 255));
            e.sel = 2'($urandom_range(0, 3));
            stim.push_back(e);
        end
        push(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
    endtask

    // Opens a pass and streams the queue; returns right after the last sample's edge.
    task automatic feed(input string name, input bit start_mid);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        for (int i = 0; i < stim.size(); i++) begin
            smp.in_valid = stim[i].v;
            smp.in_last  = stim[i].l;
            smp.in_d0    = stim[i].d0;
            smp.in_d1    = stim[i].d1;
            smp.in_sel   = stim[i].sel;
            start        = start_mid && (i == stim.size() / 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        idle_bus();
    endtask

    task automatic finish_pass(input string name, input bit start_on_done);
        int lat = 0;
        bit seen = 1'b0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        vectors++;
        if (!seen || lat != LATENCY) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d (seen=%0d) want %0d", name, lat, seen, LATENCY);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (new_v[i] !== 8'(exp_new[i])) begin
                miscompares++;
                $display("FAIL %s new[%0d]: got %0d want %0d", name, i, new_v[i], exp_new[i]);
            end
        end
        vectors++;
        if (converged !== exp_conv) begin
            miscompares++;
            $display("FAIL %s converged: got %b want %b", name, converged, exp_conv);
        end
        if (start_on_done) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (new_v[i] !== 8'(exp_new[i])) begin
                miscompares++;
                $display("FAIL %s hold_new[%0d]: got %0d want %0d", name, i, new_v[i], exp_new[i]);
            end
        end
    endtask

    task automatic run_pass(input string name, input bit start_mid, input bit start_on_done);
        model();
        feed(name, start_mid);
        finish_pass(name, start_on_done);
    endtask

    task automatic test_reset();
        idle_bus();
        for (int i = 0; i < 6; i++) old_v[i] = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0) begin
            miscompares++;
            $display("FAIL reset flags: got busy=%b done=%b conv=%b want 0 0 0", busy, done, converged);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (new_v[i] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset new[%0d]: got %0d want 0", i, new_v[i]);
            end
        end
    endtask

    task automatic basic_samples();
        stim.delete();
        push(1, 0, 10, 20, 0);
        push(1, 0, 12, 22, 0);
        push(1, 0, 100, 50, 1);
        push(1, 1, 101, 51, 1);
    endtask

    task automatic test_basic();
        int want [6] = '{11, 21, 100, 50, 7, 7};
        old_v[0] = 0; old_v[1] = 0; old_v[2] = 1; old_v[3] = 1; old_v[4] = 7; old_v[5] = 7;
        basic_samples();
        run_pass("basic", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (new_v[i] !== 8'(want[i])) begin
                miscompares++;
                $display("FAIL basic table[%0d]: got %0d want %0d", i, new_v[i], want[i]);
            end
        end
    endtask

    task automatic test_converged_back_to_back();
        old_v[0] = 11; old_v[1] = 21; old_v[2] = 100; old_v[3] = 50; old_v[4] = 7; old_v[5] = 7;
        basic_samples();
        run_pass("converged", 1'b0, 1'b1);
        vectors++;
        if (converged !== 1'b1) begin
            miscompares++;
            $display("FAIL converged held_flag: got %b want 1", converged);
        end
    endtask

    task automatic test_full_scale();
        random_old();
        stim.delete();
        for (int i = 0; i < 255; i++) push(1, 0, 255, 255, 0);
        push(1, 1, 255, 255, 0);
        run_pass("full_scale", 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        random_old();
        stim.delete();
        push(0, 0, 0, 0, 0);
        push(1, 0, 50, 60, 3);
        push(0, 1, 99, 99, 2);
        push(1, 0, 4, 8, 2);
        push(1, 0, 200, 200, 3);
        push(0, 0, 0, 0, 1);
        push(1, 1, 6, 10, 2);
        run_pass("gapped", 1'b0, 1'b0);
        vectors++;
        if (new_v[4] !== 8'd5 || new_v[5] !== 8'd9) begin
            miscompares++;
            $display("FAIL gapped k2: got (%0d,%0d) want (5,9)", new_v[4], new_v[5]);
        end
    endtask

    task automatic test_start_in_acc();
        random_old();
        gen_random(30);
        run_pass("start_in_acc", 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 5; p++) begin
            random_old();
            gen_random($urandom_range(8, 60));
            run_pass("random", 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) old_v[i] = 8'(exp_new[i]);
            run_pass("random_iter", 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_div();
        bit done_seen = 1'b0;
        random_old();
        gen_random(20);
        model();
        feed("reset_mid", 1'b0);
        repeat (3 * (DW + QB + 2) + 6) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || new_v[0] !== 8'(exp_new[0])) begin
            miscompares++;
            $display("FAIL reset_mid pre_state: got busy=%b new0=%0d want 1 %0d", busy, new_v[0], exp_new[0]);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid flags: got busy=%b done=%b conv=%b want 0 0 0", busy, done, converged);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (new_v[i] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_mid new[%0d]: got %0d want 0", i, new_v[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) done_seen = 1'b1;
        end
        vectors++;
        if (done_seen) begin
            miscompares++;
            $display("FAIL reset_mid spurious_done: got 1 want 0");
        end
        random_old();
        gen_random(25);
        run_pass("after_reset", 1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_converged_back_to_back();
        test_full_scale();
        test_gapped();
        test_start_in_acc();
        test_random();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kmeans_k3n2_centroid_update.md
# kmeans_k3n2_centroid_update

Downstream stage of the 3-centroid, 2-dimension k-means distance pipeline. It consumes each classified sample, meaning the delayed data pair plus the selected centroid index, and accumulates per-centroid coordinate sums and sample counts over one pass of the dataset. At end of pass it computes the new centroid means with a shared sequential divider. It then reports the new centroids and a convergence flag to the top-level iteration controller.

## Interface
Parameters:
- input_data_width, 8, width of one coordinate.
- input_data_qty_bit_width, 8, log2 of the maximum samples per pass (2**bits samples max).
- Derived widths:
  - SW = input_data_width + input_data_qty_bit_width, the sum width.
  - CW = input_data_qty_bit_width + 1, the count width.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that opens a pass; honoured only in IDLE.
- in_valid, input, 1, classified sample present this cycle.
- in_last, input, 1, qualifies the final sample of the pass; meaningful only with in_valid.
- in_d0, in_d1, input, input_data_width each, sample coordinates, aligned with the selected index.
- in_sel, input, 2, selected centroid index (0..2).
- old_k0d0 .. old_k2d1, input, input_data_width each (6 ports), current centroids; must be held stable during the pass.
- new_k0d0 .. new_k2d1, output, input_data_width each (6 ports), updated centroids; registered.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when all new_* are valid.
- converged, output, 1, all six new values equal their old values; valid from done until the next start.

## Operation
- FSM states: IDLE, ACC, DIV_LOAD, DIV_RUN, DIV_WRITE, DONE.
- IDLE:
  - On start, clear the six sums and three counts, then go to ACC.
- ACC:
  - On each cycle with in_valid and in_sel in 0..2: sum[sel][0] += in_d0, sum[sel][1] += in_d1, cnt[sel] += 1.
  - in_sel = 3 drops the sample; the in_last rule below still applies.
  - in_valid && in_last accepts that sample, then moves to DIV_LOAD with division index j = 0.
- Division order, j = 0..5: k0d0, k0d1, k1d0, k1d1, k2d0, k2d1.
- DIV_LOAD (1 cycle): load dividend = sum[j] and divisor = cnt of the matching centroid into the divider.
- DIV_RUN (SW cycles): restoring division, one quotient bit per cycle.
- DIV_WRITE (1 cycle):
  - If the count is nonzero, new_* for j takes quotient[input_data_width-1:0] (floor). The quotient always fits because mean ≤ max coordinate.
  - If the count is 0, new_* for j takes old_* for j and the divider result is ignored.
  - Clear the converged-accumulator bit if new differs from old.
  - If j < 5, increment j and go to DIV_LOAD; otherwise go to DONE.
- DONE (1 cycle): done = 1, converged updated, then go to IDLE.
- start outside IDLE is ignored. in_valid outside ACC is ignored.
- Sums cannot overflow: max sum (2**bits)·(2**input_data_width−1) < 2**SW. Counts hold up to 2**bits.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Sums, counts, j and divider registers 0.
- Reset asserted mid-pass or mid-divide aborts immediately. No done is issued, and new_* return to 0.
- Accumulation has zero bubble: one sample per cycle, accepted on the edge where in_valid is sampled.
- Latency: if the last sample is accepted at edge N, done is high during the cycle after edge N + 6·(SW+2). With default parameters that is edge N+108.
- A start in the same cycle as done is ignored (state is DONE, not IDLE). The earliest restart is the cycle after done.
- new_* only change in DIV_WRITE. They stay stable from done until the next pass's DIV_WRITE.

## Structure
- Shared package (kmeans_pkg):
  - Centroid index constants K0/K1/K2.
  - State encoding localparams.
  - Width-derivation functions for SW and CW.
- Sub-module kmeans_seq_divider (parameter SW):
  - Ports: load, dividend, divisor, quotient, ready.
  - Restoring algorithm, SW iterations.
  - Divisor 0 yields an all-ones quotient, which the caller discards.

## Test plan
- Basic update:
  - Stimulus: old = (0,0),(1,1),(7,7); samples (10,20,s0), (12,22,s0), (100,50,s1), (101,51,s1, last).
  - Required response: new k0 = (11,21), k1 = (100,50), k2 = (7,7); done at +108 cycles; converged = 0.
- Converged pass: same samples with old = (11,21),(100,50),(7,7) → converged = 1.
- Full-scale pass: 256 samples of (255,255) on s0 → k0 = (255,255), no overflow; k1 and k2 equal to old.
- Invalid and gapped input:
  - Stimulus: in_sel = 3 samples interleaved with gaps (in_valid low), plus valid samples (4,8,s2), (6,10,s2, last).
  - Required response: k2 = (5,9); dropped samples do not affect any count.
- Reset and ignored start:
  - Stimulus: rst low during DIV_RUN of j = 3, then a new pass.
  - Required response: outputs go to 0 at once with no done; the new pass produces correct results.
  - Also: a start pulse during ACC is ignored.
